// File: rtl/piso_pkg.sv
// Shared definitions for the piso_stream serializer: FSM state encoding
// and the divider width helper.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    GAP      = 2'd3
  } piso_state_t;

  // A divide-by-1 still needs one counter bit so the port widths stay legal.
  function automatic int div_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/piso_stream_if.sv
// Parallel load handshake into the serializer: the front end offers a word
// with valid_in, the serializer takes it while ready_out is high.
interface piso_stream_if #(
  parameter int SIZE = 40
);
  logic [SIZE-1:0] data_in;
  logic            valid_in;
  logic            ready_out;

  modport master (output data_in, output valid_in, input  ready_out);
  modport slave  (input  data_in, input  valid_in, output ready_out);
endinterface

// File: rtl/piso_bit_timer.sv
// Half-period divider for the shift clock: phase_end marks the last clk_in
// cycle of each DIV-cycle phase while enabled.
module piso_bit_timer
  import piso_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic enable,
  output logic phase_end
);

  localparam int            DW   = div_width(DIV);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      div_cnt <= '0;
    end else if (!enable || div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign phase_end = enable && (div_cnt == LAST);

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer: one word per accepted handshake, sent
// with a generated shift clock, frame enable and end-of-word pulse.
module piso_stream
  import piso_pkg::*;
#(
  parameter int SIZE      = 40,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk_in,
  input  logic          reset_n_in,
  piso_stream_if.slave  load,
  output logic          sclk_out,
  output logic          sdata_out,
  output logic          frame_out,
  output logic          done_out
);

  localparam int CW = $clog2(SIZE);

  piso_state_t     state, state_next;
  logic [SIZE-1:0] shift_reg, shift_next, shifted;
  logic [CW-1:0]   bit_cnt, bit_cnt_next;
  logic            sclk_next, sdata_next, frame_next, done_next;
  logic            first_bit, phase_end, timer_en;

  assign load.ready_out = (state == IDLE);
  assign timer_en       = (state != IDLE);

  piso_bit_timer #(.DIV(DIV)) u_timer (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .enable     (timer_en),
    .phase_end  (phase_end)
  );

  assign shifted   = MSB_FIRST ? {shift_reg[SIZE-2:0], 1'b0}
                               : {1'b0, shift_reg[SIZE-1:1]};
  assign first_bit = MSB_FIRST ? load.data_in[SIZE-1] : load.data_in[0];

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      sclk_out  <= 1'b0;
      sdata_out <= 1'b0;
      frame_out <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt_next;
      sclk_out  <= sclk_next;
      sdata_out <= sdata_next;
      frame_out <= frame_next;
      done_out  <= done_next;
    end
  end

  // Outputs are computed one cycle ahead so every serial pin comes from a flop.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
    sclk_next    = sclk_out;
    sdata_next   = sdata_out;
    frame_next   = frame_out;
    done_next    = 1'b0;

    case (state)
      IDLE: begin
        if (load.valid_in) begin
          state_next   = SHIFT_LO;
          shift_next   = load.data_in;
          bit_cnt_next = CW'(SIZE - 1);
          sclk_next    = 1'b0;
          sdata_next   = first_bit;
          frame_next   = 1'b1;
        end
      end
      SHIFT_LO: begin
        if (phase_end) begin
          state_next = SHIFT_HI;
          sclk_next  = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (phase_end) begin
          sclk_next = 1'b0;
          if (bit_cnt != '0) begin
            state_next   = SHIFT_LO;
            bit_cnt_next = bit_cnt - 1'b1;
            shift_next   = shifted;
            sdata_next   = MSB_FIRST ? shifted[SIZE-1] : shifted[0];
          end else begin
            state_next = GAP;
            frame_next = 1'b0;
            done_next  = 1'b1;
          end
        end
      end
      GAP: begin
        if (phase_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: four configurations share one clock and
// reset, and a mux routes the one under test to a common frame monitor.
module tb_piso_stream;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid;
  logic [63:0] data;
  int          sel;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  piso_stream_if #(.SIZE(8))  ifA ();
  piso_stream_if #(.SIZE(8))  ifB ();
  piso_stream_if #(.SIZE(2))  ifC ();
  piso_stream_if #(.SIZE(40)) ifD ();

  assign ifA.valid_in = valid && (sel == 0);
  assign ifB.valid_in = valid && (sel == 1);
  assign ifC.valid_in = valid && (sel == 2);
  assign ifD.valid_in = valid && (sel == 3);
  assign ifA.data_in  = data[7:0];
  assign ifB.data_in  = data[7:0];
  assign ifC.data_in  = data[1:0];
  assign ifD.data_in  = data[39:0];

  logic sclkA, sdataA, frameA, doneA;
  logic sclkB, sdataB, frameB, doneB;
  logic sclkC, sdataC, frameC, doneC;
  logic sclkD, sdataD, frameD, doneD;

  piso_stream #(.SIZE(8), .DIV(2), .MSB_FIRST(1'b1)) dutA (
    .clk_in(clk), .reset_n_in(reset_n), .load(ifA.slave),
    .sclk_out(sclkA), .sdata_out(sdataA), .frame_out(frameA), .done_out(doneA));
  piso_stream #(.SIZE(8), .DIV(2), .MSB_FIRST(1'b0)) dutB (
    .clk_in(clk), .reset_n_in(reset_n), .load(ifB.slave),
    .sclk_out(sclkB), .sdata_out(sdataB), .frame_out(frameB), .done_out(doneB));
  piso_stream #(.SIZE(2), .DIV(1), .MSB_FIRST(1'b1)) dutC (
    .clk_in(clk), .reset_n_in(reset_n), .load(ifC.slave),
    .sclk_out(sclkC), .sdata_out(sdataC), .frame_out(frameC), .done_out(doneC));
  piso_stream dutD (
    .clk_in(clk), .reset_n_in(reset_n), .load(ifD.slave),
    .sclk_out(sclkD), .sdata_out(sdataD), .frame_out(frameD), .done_out(doneD));

  logic mSclk, mSdata, mFrame, mDone, mReady;

  always_comb begin
    mSclk  = sclkA;
    mSdata = sdataA;
    mFrame = frameA;
    mDone  = doneA;
    mReady = ifA.ready_out;
    case (sel)
      1: begin mSclk = sclkB; mSdata = sdataB; mFrame = frameB; mDone = doneB; mReady = ifB.ready_out; end
      2: begin mSclk = sclkC; mSdata = sdataC; mFrame = frameC; mDone = doneC; mReady = ifC.ready_out; end
      3: begin mSclk = sclkD; mSdata = sdataD; mFrame = frameD; mDone = doneD; mReady = ifD.ready_out; end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Offers one word for a single edge, then scrambles data to show it is not re-sampled.
  task automatic applyStimulus(input int which, input logic [63:0] word);
    @(negedge clk);
    sel   = which;
    data  = word;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = ~word;
  endtask

  task automatic measureFrame(input int budget, output int rises, output logic [63:0] bits,
                              output logic [63:0] sclkHist, output logic [3:0] first,
                              output int frameCnt, output int doneAt, output int doneCnt,
                              output int readyAt);
    logic prevSclk;
    prevSclk = 1'b0;
    rises = 0; bits = '0; sclkHist = '0; first = '0;
    frameCnt = 0; doneAt = -1; doneCnt = 0; readyAt = -1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 1) first = {mFrame, mSclk, mSdata, mReady};
      sclkHist = {sclkHist[62:0], mSclk};
      if (mSclk && !prevSclk) begin
        rises++;
        bits = {bits[62:0], mSdata};
      end
      prevSclk = mSclk;
      if (mFrame) frameCnt++;
      if (mDone) begin
        doneCnt++;
        if (doneAt < 0) doneAt = n;
      end
      if (mReady) begin
        readyAt = n;
        break;
      end
    end
  endtask

  int          rises, frameCnt, doneAt, doneCnt, readyAt;
  int          readyCnt, firstReadyAt, secondReadyAt, notReady;
  logic [63:0] bits, sclkHist, acceptData;
  logic [3:0]  first;
  logic        prevSclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    valid   = 1'b0;
    data    = '0;
    sel     = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", ifA.ready_out, 1);
    checkOutput("rst_sclk",  sclkA, 0);
    checkOutput("rst_sdata", sdataA, 0);
    checkOutput("rst_frame", frameA, 0);
    checkOutput("rst_done",  doneA, 0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", ifA.ready_out, 1);

    // MSB first, 8'hA5
    applyStimulus(0, 64'hA5);
    measureFrame(60, rises, bits, sclkHist, first, frameCnt, doneAt, doneCnt, readyAt);
    checkOutput("A_first",   first, 4'b1010);
    checkOutput("A_bits",    bits[7:0], 8'hA5);
    checkOutput("A_rises",   rises, 8);
    checkOutput("A_frame",   frameCnt, 32);
    checkOutput("A_doneAt",  doneAt, 33);
    checkOutput("A_doneCnt", doneCnt, 1);
    checkOutput("A_readyAt", readyAt, 35);

    // LSB first, 8'h01 gives 1 then seven zeros
    applyStimulus(1, 64'h01);
    measureFrame(60, rises, bits, sclkHist, first, frameCnt, doneAt, doneCnt, readyAt);
    checkOutput("B_first",   first, 4'b1010);
    checkOutput("B_bits",    bits[7:0], 8'h80);
    checkOutput("B_rises",   rises, 8);
    checkOutput("B_readyAt", readyAt, 35);

    // DIV=1, SIZE=2
    applyStimulus(2, 64'h2);
    measureFrame(20, rises, bits, sclkHist, first, frameCnt, doneAt, doneCnt, readyAt);
    checkOutput("C_bits",    bits[1:0], 2'b10);
    checkOutput("C_rises",   rises, 2);
    checkOutput("C_sclk",    sclkHist[5:0], 6'b010100);
    checkOutput("C_frame",   frameCnt, 4);
    checkOutput("C_doneAt",  doneAt, 5);
    checkOutput("C_readyAt", readyAt, 6);

    // Default 40-bit word, DIV=4
    applyStimulus(3, 64'hC35A0F96E1);
    measureFrame(400, rises, bits, sclkHist, first, frameCnt, doneAt, doneCnt, readyAt);
    checkOutput("D_bits",    bits[39:0], 40'hC35A0F96E1);
    checkOutput("D_rises",   rises, 40);
    checkOutput("D_doneAt",  doneAt, 321);
    checkOutput("D_readyAt", readyAt, 325);

    // valid held high while busy, data changing every cycle
    @(negedge clk);
    sel   = 0;
    data  = 64'h11;
    valid = 1'b1;
    @(posedge clk);
    readyCnt = 0; firstReadyAt = -1; secondReadyAt = -1;
    rises = 0; bits = '0; prevSclk = 1'b0; acceptData = '0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      data = 64'h20 + 64'(n);
      if (sclkA && !prevSclk) begin
        rises++;
        bits = {bits[62:0], sdataA};
      end
      prevSclk = sclkA;
      if (ifA.ready_out) begin
        readyCnt++;
        if (readyCnt == 1) begin
          firstReadyAt = n;
          acceptData   = data;
        end else begin
          secondReadyAt = n;
          valid = 1'b0;
          break;
        end
      end
    end
    valid = 1'b0;
    checkOutput("busy_spacing1", firstReadyAt, 35);
    checkOutput("busy_spacing2", secondReadyAt, 70);
    checkOutput("busy_accept",   acceptData[7:0], 8'h43);
    checkOutput("busy_rises",    rises, 16);
    checkOutput("busy_bits",     bits[15:0], 16'h1143);

    // Reset in the high phase of bit 3 of 8'h1F
    applyStimulus(0, 64'h1F);
    repeat (15) @(negedge clk);
    checkOutput("pre_rst_sclk",  sclkA, 1);
    checkOutput("pre_rst_sdata", sdataA, 1);
    checkOutput("pre_rst_frame", frameA, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_sclk",  sclkA, 0);
    checkOutput("mid_rst_sdata", sdataA, 0);
    checkOutput("mid_rst_frame", frameA, 0);
    checkOutput("mid_rst_ready", ifA.ready_out, 1);
    checkOutput("mid_rst_done",  doneA, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    doneCnt = 0; notReady = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (doneA) doneCnt++;
      if (!ifA.ready_out) notReady++;
    end
    checkOutput("post_rst_done",  doneCnt, 0);
    checkOutput("post_rst_ready", notReady, 0);
    applyStimulus(0, 64'hFF);
    measureFrame(60, rises, bits, sclkHist, first, frameCnt, doneAt, doneCnt, readyAt);
    checkOutput("post_rst_bits",    bits[7:0], 8'hFF);
    checkOutput("post_rst_rises",   rises, 8);
    checkOutput("post_rst_readyAt", readyAt, 35);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, programmable bit rate and bit order, and framing outputs.

- Successor to the fixed-width free-running shifter: shifts one word per accepted transaction instead of continuously.
- Generates its own shift clock and an active-high frame enable.
- Sits between the driver-register front end and the stepper-driver serial configuration pins.

## Interface

Parameters:
- SIZE, default 40: word width in bits; must be ≥ 2.
- DIV, default 4: clk_in cycles per shift-clock half-period; must be ≥ 1.
- MSB_FIRST, default 1:
  - 1 = data_in[SIZE-1] is sent first.
  - 0 = data_in[0] is sent first.

Ports:
- clk_in  input  1: single system clock; all logic on its rising edge.
- reset_n_in  input  1: asynchronous, active-low reset.
- data_in  input  SIZE: parallel word; sampled only on an accepted handshake.
- valid_in  input  1: data_in holds a word to send.
- ready_out  output  1: block is idle and can accept a word.
- sclk_out  output  1: shift clock; idles low.
- sdata_out  output  1: serial data; changes on sclk_out falling edges, stable across rising edges.
- frame_out  output  1: high for the whole word transfer.
- done_out  output  1: one-cycle pulse when the last bit completes.

## Operation

- Accept condition: valid_in && ready_out at a rising clk_in edge with reset_n_in high. data_in is latched into an internal SIZE-bit shift register.
- Changes to data_in after acceptance have no effect.
- valid_in while ready_out is low is ignored; no queueing.
- State machine:
  - IDLE: ready_out = 1. On accept → SHIFT; bit counter = SIZE-1, divider = 0.
  - SHIFT, low phase: sclk_out = 0 for DIV cycles, then → high phase.
  - SHIFT, high phase: sclk_out = 1 for DIV cycles. At the end of the phase:
    - bit counter ≠ 0: decrement it, shift the register by one in the configured direction, present the next bit, return to the low phase.
    - bit counter = 0: → GAP.
  - GAP: frame_out = 0, sclk_out = 0 for DIV cycles, then → IDLE. done_out pulses in the first GAP cycle.
- ready_out is decoded from state == IDLE.
- Counter widths:
  - Bit counter: $clog2(SIZE) bits.
  - Divider: max(1, $clog2(DIV)) bits. It counts 0..DIV-1 and wraps to 0 on every phase change.
- Reset (asynchronous, any state, including mid-frame). Outputs go immediately to:
  - state IDLE, ready_out = 1;
  - sclk_out = 0, sdata_out = 0, frame_out = 0, done_out = 0;
  - shift register and counters = 0.
- A partial frame is abandoned and not resumed.

## Timing

- Accept at edge k.
- From cycle k+1:
  - frame_out = 1, sclk_out = 0;
  - sdata_out = first bit;
  - ready_out = 0.
- Bit n (0-based):
  - driven from cycle k+1+2·DIV·n;
  - sclk_out rises at k+1+2·DIV·n+DIV.
- Cycle k+1+2·DIV·SIZE:
  - frame_out = 0, sclk_out = 0;
  - done_out = 1 for exactly one cycle;
  - sdata_out holds the last bit.
- ready_out = 1 from cycle k+1+2·DIV·SIZE+DIV.
- Minimum accept-to-accept period: 2·DIV·SIZE+DIV+1 cycles; back-to-back accepts achieve exactly this.
- All outputs are registered except ready_out (state decode).

## Structure

- Package piso_pkg holds:
  - state encoding localparams (IDLE, SHIFT_LO, SHIFT_HI, GAP);
  - the width helper for the counters.
- Sub-module piso_bit_timer holds the DIV divider.
  - Inputs: clk_in, reset_n_in, enable.
  - Output: a one-cycle phase_end pulse.
  - The top holds the FSM, shift register and bit counter.

## Test plan

- SIZE=8, DIV=2, MSB_FIRST=1, data 8'hA5:
  - sdata_out sampled at the 8 sclk_out rising edges = 1,0,1,0,0,1,0,1;
  - frame_out high for 32 cycles;
  - done_out pulse at cycle k+33;
  - ready_out back at k+35.
- SIZE=8, DIV=2, MSB_FIRST=0, data 8'h01: sampled bits = 1,0,0,0,0,0,0,0.
- Busy-state stimulus:
  - valid_in held high with data changing every cycle while busy: exactly one word is sent per frame.
  - The second word is the value present at the edge where ready_out returns high.
  - Accept-to-accept spacing = 35 cycles.
- Reset asserted during bit 3:
  - same cycle: sclk_out = 0, sdata_out = 0, frame_out = 0, ready_out = 1;
  - no done_out pulse;
  - after release, a fresh word 8'hFF transmits all ones.
- Divider and widths at the limits:
  - DIV=1, SIZE=2, data 2'b10: sclk_out toggles every cycle; bits = 1,0; done_out at k+5.
  - SIZE=40 default: 40 rising edges per frame.
